// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and full-flag controller for an asynchronous FIFO.
// Keeps binary and Gray write pointers, the full/almost-full flags, the write-side level and a sticky overflow flag.
module wptr_full_ctrl #(
    parameter int ADDRSIZE     = 4,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic                ovf_clr,
    output logic                wfull,
    output logic                awfull,
    output logic                wclken,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                wovf
);

    localparam int DEPTH = 1 << ADDRSIZE;
    localparam logic [ADDRSIZE:0] AFULL_TH = (ADDRSIZE+1)'(DEPTH - AFULL_MARGIN);

    logic [ADDRSIZE:0] r_wbin;
    logic [ADDRSIZE:0] r_wptr;
    logic              r_wfull;
    logic              r_awfull;
    logic [ADDRSIZE:0] r_wlevel;
    logic              r_wovf;

    logic              w_inc;
    logic [ADDRSIZE:0] w_wbinnext;
    logic [ADDRSIZE:0] w_wgraynext;
    logic [ADDRSIZE:0] w_rbin;
    logic [ADDRSIZE:0] w_lvl_next;
    logic              w_wfull_val;

    function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        b[ADDRSIZE] = g[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // The write is gated by the registered full flag, so a full FIFO never accepts data.
    assign w_inc       = winc & ~r_wfull;
    assign w_wbinnext  = r_wbin + {{ADDRSIZE{1'b0}}, w_inc};
    assign w_wgraynext = (w_wbinnext >> 1) ^ w_wbinnext;
    assign w_rbin      = gray2bin(wq2_rptr);
    assign w_lvl_next  = w_wbinnext - w_rbin;
    // Full when the pointers differ only in the two MSBs of their Gray encodings.
    assign w_wfull_val = (w_wgraynext ==
                          {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wbin   <= '0;
            r_wptr   <= '0;
            r_wfull  <= 1'b0;
            r_awfull <= 1'b0;
            r_wlevel <= '0;
            r_wovf   <= 1'b0;
        end else begin
            r_wbin   <= w_wbinnext;
            r_wptr   <= w_wgraynext;
            r_wfull  <= w_wfull_val;
            r_awfull <= (w_lvl_next >= AFULL_TH);
            r_wlevel <= w_lvl_next;
            // Set has priority over clear so a coincident overflow is never lost.
            if (winc & r_wfull) begin
                r_wovf <= 1'b1;
            end else if (ovf_clr) begin
                r_wovf <= 1'b0;
            end
        end
    end

    assign wfull  = r_wfull;
    assign awfull = r_awfull;
    assign wclken = w_inc;
    assign waddr  = r_wbin[ADDRSIZE-1:0];
    assign wptr   = r_wptr;
    assign wlevel = r_wlevel;
    assign wovf   = r_wovf;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed bench for wptr_full_ctrl at ADDRSIZE=4, AFULL_MARGIN=2.
module tb_wptr_full_ctrl;

    logic       wclk = 1'b0;
    logic       wrst_n = 1'b1;
    logic       winc = 1'b0;
    logic [4:0] wq2_rptr = '0;
    logic       ovf_clr = 1'b0;
    logic       wfull, awfull, wclken, wovf;
    logic [3:0] waddr;
    logic [4:0] wptr, wlevel;

    int n_cmp = 0;
    int n_err = 0;

    always #5 wclk = ~wclk;

    wptr_full_ctrl #(.ADDRSIZE(4), .AFULL_MARGIN(2)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wq2_rptr(wq2_rptr),
        .ovf_clr(ovf_clr), .wfull(wfull), .awfull(awfull), .wclken(wclken),
        .waddr(waddr), .wptr(wptr), .wlevel(wlevel), .wovf(wovf)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    function automatic logic [4:0] g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [4:0] exp_bin;
        logic [4:0] prev;

        // reset state
        #1 wrst_n = 1'b0;
        #1;
        chk("rst_wfull", wfull, 0);
        chk("rst_awfull", awfull, 0);
        chk("rst_wptr", wptr, 0);
        chk("rst_wlevel", wlevel, 0);
        chk("rst_wovf", wovf, 0);
        chk("rst_waddr", waddr, 0);
        tick();
        wrst_n = 1'b1;

        // fill 16 entries with the reader parked at 0
        for (int i = 0; i < 16; i++) begin
            winc = 1'b1;
            #1;
            chk("fill_waddr", waddr, i);
            chk("fill_wclken", wclken, 1);
            tick();
            chk("fill_wlevel", wlevel, i + 1);
            chk("fill_awfull", awfull, (i + 1 >= 14));
            chk("fill_wfull", wfull, (i == 15));
        end
        winc = 1'b0;
        chk("fill_wptr", wptr, 5'b11000);

        // writes while full
        winc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ovf_wclken", wclken, 0);
            chk("ovf_waddr", waddr, 0);
            tick();
            chk("ovf_wovf", wovf, 1);
            chk("ovf_wptr", wptr, 5'b11000);
            chk("ovf_wfull", wfull, 1);
        end
        winc = 1'b0;
        ovf_clr = 1'b1;
        tick();
        chk("clr_wovf", wovf, 0);
        winc = 1'b1;
        tick();
        chk("setwins_wovf", wovf, 1);
        winc = 1'b0;
        tick();
        chk("clr2_wovf", wovf, 0);
        ovf_clr = 1'b0;

        // reader frees one slot
        wq2_rptr = 5'b00001;
        tick();
        chk("free_wfull", wfull, 0);
        chk("free_wlevel", wlevel, 15);
        chk("free_awfull", awfull, 1);
        winc = 1'b1;
        #1;
        chk("free_waddr", waddr, 0);
        chk("free_wclken", wclken, 1);
        tick();
        winc = 1'b0;
        chk("refill_wfull", wfull, 1);
        chk("refill_wlevel", wlevel, 16);
        chk("refill_wptr", wptr, 5'b11001);

        // streaming with the reader two entries behind, across the pointer wrap
        wrst_n = 1'b0;
        wq2_rptr = '0;
        tick();
        wrst_n = 1'b1;
        winc = 1'b1;
        tick();
        tick();
        exp_bin = 5'd2;
        chk("strm_start_wlevel", wlevel, 2);
        prev = wptr;
        for (int k = 0; k < 40; k++) begin
            wq2_rptr = g(exp_bin - 5'd1);
            tick();
            exp_bin = exp_bin + 5'd1;
            chk("strm_wlevel", wlevel, 2);
            chk("strm_wfull", wfull, 0);
            chk("strm_wptr", wptr, g(exp_bin));
            chk("strm_wptr_1bit", $countones(wptr ^ prev), 1);
            prev = wptr;
        end
        winc = 1'b0;

        // asynchronous reset mid-burst
        wrst_n = 1'b0;
        tick();
        wrst_n = 1'b1;
        wq2_rptr = '0;
        winc = 1'b1;
        repeat (9) tick();
        chk("mid_wlevel", wlevel, 9);
        #2;
        wrst_n = 1'b0;
        #1;
        chk("async_wfull", wfull, 0);
        chk("async_awfull", awfull, 0);
        chk("async_wptr", wptr, 0);
        chk("async_wlevel", wlevel, 0);
        chk("async_wovf", wovf, 0);
        chk("async_waddr", waddr, 0);
        winc = 1'b0;
        @(negedge wclk);
        wrst_n = 1'b1;
        winc = 1'b1;
        #1;
        chk("post_waddr", waddr, 0);
        chk("post_wclken", wclken, 1);
        tick();
        winc = 1'b0;
        chk("post_wlevel", wlevel, 1);
        chk("post_waddr1", waddr, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wptr_full_ctrl.md
WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 4, meaning FIFO address width; depth DEPTH = 2^ADDRSIZE; legal range ADDRSIZE >= 2.
REQ-002 SHALL have parameter AFULL_MARGIN, default 2, meaning the almost-full threshold in free slots; legal range 0..DEPTH-1.
REQ-003 SHALL have port wclk, input, 1 bit, write-domain clock; all state updates on its rising edge.
REQ-004 SHALL have port wrst_n, input, 1 bit, reset; asynchronous, active-low.
REQ-005 SHALL have port winc, input, 1 bit, write request.
REQ-006 SHALL have port wq2_rptr, input, ADDRSIZE+1 bits, Gray read pointer already synchronized into wclk.
REQ-007 SHALL have port ovf_clr, input, 1 bit, clears the sticky overflow flag.
REQ-008 SHALL have port wfull, output, 1 bit, registered full flag.
REQ-009 SHALL have port awfull, output, 1 bit, registered almost-full flag.
REQ-010 SHALL have port wclken, output, 1 bit, memory write enable.
REQ-011 SHALL have port waddr, output, ADDRSIZE bits, binary memory write address.
REQ-012 SHALL have port wptr, output, ADDRSIZE+1 bits, registered Gray write pointer for the read-side synchronizer.
REQ-013 SHALL have port wlevel, output, ADDRSIZE+1 bits, registered occupancy as seen from the write side, range 0..DEPTH.
REQ-014 SHALL have port wovf, output, 1 bit, sticky overflow error flag.

Function
REQ-015 SHALL hold a binary pointer wbin (ADDRSIZE+1 bits) and drive waddr = wbin[ADDRSIZE-1:0].
REQ-016 SHALL compute wbinnext = wbin + (winc & ~wfull), modulo 2^(ADDRSIZE+1).
REQ-017 SHALL compute wgraynext = (wbinnext >> 1) ^ wbinnext.
REQ-018 SHALL register wbin <= wbinnext and wptr <= wgraynext every cycle, so wptr is never combinational.
REQ-019 SHALL drive wclken = winc & ~wfull combinationally, using the registered wfull.
REQ-020 SHALL compute wfull_val = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}) and register wfull <= wfull_val.
REQ-021 SHALL convert wq2_rptr to binary rbin_s combinationally (each bit i = XOR of wq2_rptr bits ADDRSIZE..i).
REQ-022 SHALL compute lvl_next = wbinnext - rbin_s, modulo 2^(ADDRSIZE+1), and register wlevel <= lvl_next.
REQ-023 SHALL register awfull <= (lvl_next >= DEPTH - AFULL_MARGIN); awfull is therefore high whenever wfull is high.
REQ-024 SHALL assert wfull on the clock edge that commits the DEPTH-th unread write, with zero-cycle gap, so a write is never accepted when the memory is full.
REQ-025 SHALL keep wfull deasserted no earlier than the cycle after wq2_rptr advances; deassertion is pessimistic by the synchronizer latency.
REQ-026 SHALL ignore a write while wfull=1: wbin, wptr and the memory stay unchanged and wclken=0.
REQ-027 SHALL set wovf <= 1 on a cycle with winc & wfull; ovf_clr clears it the next cycle; when set and clear coincide, set wins.
REQ-028 SHALL handle pointer wrap (wbin from 2^(ADDRSIZE+1)-1 to 0) with no false full, no false level and no glitch in wptr, which changes exactly one bit per increment.

Reset
REQ-029 SHALL, while wrst_n=0, force asynchronously and without a clock: wbin=0, wptr=0, wfull=0, awfull=0, wlevel=0, wovf=0; waddr=0 follows.
REQ-030 SHALL resume normal operation on the first wclk rising edge after wrst_n deasserts; a reset mid-burst discards all pointer state.

Verification (ADDRSIZE=4, AFULL_MARGIN=2)
REQ-031 Verification SHALL cover: reset, wq2_rptr=0, 16 consecutive winc -> waddr 0..15, wclken high 16 cycles; awfull=1 after the 14th write; wfull=1, wlevel=16 and wptr=5'b11000 after the 16th write.
REQ-032 Verification SHALL cover: full state, winc=1 for 3 cycles -> wclken=0, waddr stays 0, wovf=1; ovf_clr pulse -> wovf=0; winc & wfull together with ovf_clr -> wovf stays 1.
REQ-033 Verification SHALL cover: full state, wq2_rptr set to 5'b00001 -> next cycle wfull=0, wlevel=15, awfull=1; one write -> wfull=1 again, waddr was 0.
REQ-034 Verification SHALL cover: streaming 40 writes with wq2_rptr tracking 2 entries behind -> wlevel=2 every cycle, wfull never set, wptr single-bit changes across the 31->0 wrap.
REQ-035 Verification SHALL cover: wrst_n dropped asynchronously mid-burst at wlevel=9 -> all outputs 0 immediately, before any wclk edge; the first write after release uses waddr=0.
